wb_txn_sequencer: RTL

Parametrised successor to the single-shot register-driven wishbone bridge. Queues up to CMD_DEPTH wishbone transactions and issues them back-to-back to the link wishbone master with one outstanding. Returns one tagged response per transaction through a response FIFO, with per-transaction timeout, error classification and saturating statistics counters.
Sits between the AXI register/DMA front end and the link wishbone master, all on the link clock.

---
 rtl/wb_txn_pkg.sv | 14 +
 rtl/wb_txn_sequencer_if.sv | 22 ++
 rtl/wb_txn_sequencer_fifo.sv | 37 +++
 rtl/wb_txn_sequencer.sv | 99 +++++++++
 4 files changed

// File: rtl/wb_txn_pkg.sv
// wb_txn_pkg: status codes, FSM states and record widths shared by the transaction sequencer
package wb_txn_pkg;
  localparam int ST_W = 2;
  localparam int DUR_W = 12;
  localparam logic [DUR_W-1:0] DUR_MAX = '1;
  typedef enum logic [ST_W-1:0] {ST_OK = 2'b00, ST_WBERR = 2'b01, ST_TIMEOUT = 2'b10} status_t;
  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;
  function automatic int cmd_w(input int addr_w, input int tgt_w, input int data_w);
    return 1 + tgt_w + addr_w + data_w;
  endfunction
  function automatic int rsp_w(input int data_w);
    return data_w + ST_W + 1;
  endfunction
endpackage

// File: rtl/wb_txn_sequencer_if.sv
// wb_txn_sequencer_if: command, response and link-wishbone signals of the sequencer
interface wb_txn_sequencer_if #(parameter int ADDR_W = 18, TGT_W = 5, DATA_W = 32);
  logic cmd_valid, cmd_ready, cmd_we;
  logic [TGT_W-1:0] cmd_target;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic rsp_valid, rsp_ready, rsp_we;
  logic [DATA_W-1:0] rsp_data;
  logic [1:0] rsp_status;
  logic wb_str, wb_we, wb_ack, wb_err;
  logic [ADDR_W-1:0] wb_addr;
  logic [TGT_W-1:0] wb_target;
  logic [DATA_W-1:0] wb_dato, wb_dati;
  modport slave (
    input cmd_valid, cmd_we, cmd_target, cmd_addr, cmd_data, rsp_ready, wb_ack, wb_err, wb_dati,
    output cmd_ready, rsp_valid, rsp_data, rsp_status, rsp_we, wb_str, wb_we, wb_addr, wb_target, wb_dato
  );
  modport master (
    output cmd_valid, cmd_we, cmd_target, cmd_addr, cmd_data, rsp_ready, wb_ack, wb_err, wb_dati,
    input cmd_ready, rsp_valid, rsp_data, rsp_status, rsp_we, wb_str, wb_we, wb_addr, wb_target, wb_dato
  );
endinterface

// File: rtl/wb_txn_sequencer_fifo.sv
// sync_fifo: first-word fall-through FIFO with flush, legal simultaneous push/pop at any occupancy
module sync_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_push, do_pop;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign empty = wp == rp;
  assign full = (wp ^ rp) == {1'b1, {AW{1'b0}}};
  assign dout = mem[rp[AW-1:0]];
  // read/write pointers; flush empties the queue
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= flush ? '0 : wp + {{AW{1'b0}}, do_push};
      rp <= flush ? '0 : rp + {{AW{1'b0}}, do_pop};
    end
  // storage, no reset needed since reads are qualified by empty
  always_ff @(posedge clk)
    if (do_push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/wb_txn_sequencer.sv
// wb_txn_sequencer: queues wishbone transactions, issues them one at a time, returns tagged responses
module wb_txn_sequencer
  import wb_txn_pkg::*;
#(
  parameter int ADDR_W = 18,
  parameter int TGT_W = 5,
  parameter int DATA_W = 32,
  parameter int CMD_DEPTH = 16,
  parameter int RSP_DEPTH = 16,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W = 16
) (
  input  logic clk_link,
  input  logic reset,
  input  logic flush,
  input  logic count_clear,
  wb_txn_sequencer_if.slave bus,
  output logic busy,
  output logic [DUR_W-1:0] last_duration,
  output logic [CNT_W-1:0] txn_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] timeout_count
);
  localparam int CW = cmd_w(ADDR_W, TGT_W, DATA_W);
  localparam int RW = rsp_w(DATA_W);
  state_t state, state_nx;
  status_t st;
  logic launch, done, cmd_empty, cmd_full, rsp_empty, rsp_full;
  logic [CW-1:0] cmd_q;
  logic [RW-1:0] rsp_q;
  logic [31:0] timer;
  function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
  sync_fifo #(.W(CW), .DEPTH(CMD_DEPTH)) u_cmd (
    .clk(clk_link), .rst(reset), .flush(flush),
    .push(bus.cmd_valid && !cmd_full), .pop(launch),
    .din({bus.cmd_we, bus.cmd_target, bus.cmd_addr, bus.cmd_data}),
    .dout(cmd_q), .full(cmd_full), .empty(cmd_empty)
  );
  sync_fifo #(.W(RW), .DEPTH(RSP_DEPTH)) u_rsp (
    .clk(clk_link), .rst(reset), .flush(flush),
    .push(done), .pop(bus.rsp_ready && !rsp_empty),
    .din({(st == ST_OK && !bus.wb_we) ? bus.wb_dati : {DATA_W{1'b0}}, st, bus.wb_we}),
    .dout(rsp_q), .full(rsp_full), .empty(rsp_empty)
  );
  assign bus.cmd_ready = !cmd_full;
  assign bus.rsp_valid = !rsp_empty;
  assign {bus.rsp_data, bus.rsp_status, bus.rsp_we} = rsp_empty ? '0 : rsp_q;
  assign bus.wb_str = state == ACTIVE;
  assign busy = state != IDLE || !cmd_empty;
  // next state and completion classification; error beats ack, both beat timeout
  always_comb begin
    launch = 1'b0;
    done = 1'b0;
    st = ST_OK;
    state_nx = state;
    if (flush) state_nx = GAP;
    else
      case (state)
        IDLE: begin
          launch = !cmd_empty && !rsp_full;
          state_nx = launch ? ACTIVE : IDLE;
        end
        ACTIVE: begin
          done = bus.wb_ack || bus.wb_err || timer == 32'(TIMEOUT - 1);
          st = bus.wb_err ? ST_WBERR : bus.wb_ack ? ST_OK : ST_TIMEOUT;
          state_nx = done ? GAP : ACTIVE;
        end
        default: state_nx = IDLE;
      endcase
  end
  // state register
  always_ff @(posedge clk_link or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  // launched command fields and per-transaction strobe timer
  always_ff @(posedge clk_link or posedge reset)
    if (reset) begin
      {bus.wb_we, bus.wb_target, bus.wb_addr, bus.wb_dato} <= '0;
      timer <= '0;
    end else begin
      if (launch) {bus.wb_we, bus.wb_target, bus.wb_addr, bus.wb_dato} <= cmd_q;
      timer <= (state == ACTIVE && !done && !flush) ? timer + 1 : '0;
    end
  // saturating statistics; clear beats a simultaneous increment
  always_ff @(posedge clk_link or posedge reset)
    if (reset) begin
      last_duration <= '0;
      txn_count <= '0;
      err_count <= '0;
      timeout_count <= '0;
    end else begin
      if (done) last_duration <= (timer >= 32'(DUR_MAX)) ? DUR_MAX : timer[DUR_W-1:0] + 1'b1;
      txn_count <= count_clear ? '0 : done ? sat(txn_count) : txn_count;
      err_count <= count_clear ? '0 : (done && st == ST_WBERR) ? sat(err_count) : err_count;
      timeout_count <= count_clear ? '0 : (done && st == ST_TIMEOUT) ? sat(timeout_count) : timeout_count;
    end
endmodule
